// File: rtl/flop_bank_arbiter.sv
// Purpose : shares one DEPTH x WIDTH flop bank among NREQ requesters, one handshaked read/write at a time.
// Latency : req sampled in cycle 0 -> gnt in cycles 1-2 -> ack/rdata in cycle 2 -> bank_q updated in cycle 3.
// Backpressure: a requester holds req until its ack; others wait in IDLE. Throughput is one access per 3 cycles.
//
// Ports:
//   clk_i      single clock, all logic on posedge
//   rst_i      synchronous active-high reset; beats everything, including a write in flight
//   req_i      per-requester request, held until ack (may be dropped during GRANT to abort)
//   we_i       per-requester direction, 1 = write, 0 = read
//   addr_i     per-requester entry address, requester i at [i*AW +: AW]
//   wdata_i    per-requester write data, requester i at [i*WIDTH +: WIDTH]
//   gnt_o      one-hot grant, registered, high in GRANT and DONE
//   ack_o      one-hot completion pulse, registered, high in DONE
//   rdata_o    read data, valid with ack of a read, held until the next read completes
//   busy_o     high whenever the FSM is not IDLE
//   bank_q_o   bank contents, entry k at [k*WIDTH +: WIDTH]
//
// Build option: define FIXED_PRIO_EN to replace round-robin with fixed priority
// (lowest index wins, no rotation pointer).

module flop_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*AW-1:0]       addr_i,
    input  logic [NREQ*WIDTH-1:0]    wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          ack_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     busy_o,
    output logic [DEPTH*WIDTH-1:0]   bank_q_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Registered state
    logic [PW-1:0]     win_q,   win_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic [WIDTH-1:0]  bank_q [DEPTH];

    // Selection / handshake helpers
    logic              any_req;
    logic              win_found;
    logic              win_req;
    logic              cur_we;
    logic [AW-1:0]     cur_addr;
    logic [WIDTH-1:0]  cur_wdata;
    logic              cur_addr_ok;
    logic              q_addr_ok;
    logic              latch_en;
    logic              rd_en;
    logic              wr_en;

    assign any_req = |req_i;

    //------------------------------------------------------------------
    // Winner selection (only used while IDLE)
    //------------------------------------------------------------------
`ifdef FIXED_PRIO_EN
    // Lowest active index always wins; higher indices may starve.
    always_comb begin
        win_d     = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_i[k]) begin
                win_found = 1'b1;
                win_d     = PW'(k);
            end
        end
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps NREQ-1 -> 0.
    always_comb begin
        int idx;
        idx       = 0;
        win_d     = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_d     = PW'(idx);
            end
        end
    end

    // The pointer only moves on a completed access; aborts leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE) begin
            ptr_d = PW'((int'(win_q) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    //------------------------------------------------------------------
    // Current winner's request fields (meaningful in GRANT)
    //------------------------------------------------------------------
    assign win_req     = req_i[win_q];
    assign cur_we      = we_i[win_q];
    assign cur_addr    = addr_i[int'(win_q)*AW +: AW];
    assign cur_wdata   = wdata_i[int'(win_q)*WIDTH +: WIDTH];
    assign cur_addr_ok = (int'(cur_addr) < DEPTH);
    assign q_addr_ok   = (int'(addr_q) < DEPTH);

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req ? GRANT : IDLE;
            GRANT:   state_d = win_req ? DONE : IDLE;   // dropped req = abort
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs (next values of the registered gnt/ack and enables)
    //------------------------------------------------------------------
    always_comb begin
        gnt_d    = '0;
        ack_d    = '0;
        latch_en = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d = NREQ'(1) << win_d;
                end
            end
            GRANT: begin
                if (win_req) begin
                    gnt_d    = NREQ'(1) << win_q;
                    ack_d    = NREQ'(1) << win_q;
                    latch_en = 1'b1;
                    // Read data is captured here so it lines up with ack in DONE.
                    rd_en    = !cur_we;
                end
            end
            DONE: begin
                // Out-of-range writes are dropped but still acknowledged.
                wr_en = we_q && q_addr_ok;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // Out-of-range reads return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = cur_addr_ok ? bank_q[cur_addr] : '0;
        end
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && any_req) begin
                win_q <= win_d;
            end
            if (latch_en) begin
                we_q    <= cur_we;
                addr_q  <= cur_addr;
                wdata_q <= cur_wdata;
            end
        end
    end

    // Reset has priority, so a write whose DONE cycle sees rst is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                bank_q[k] <= '0;
            end
        end else if (wr_en) begin
            bank_q[addr_q] <= wdata_q;
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != IDLE);

    for (genvar k = 0; k < DEPTH; k++) begin : g_bank_out
        assign bank_q_o[k*WIDTH +: WIDTH] = bank_q[k];
    end

endmodule

// File: tb/tb_flop_bank_arbiter.sv
// Purpose : directed check of flop_bank_arbiter: reset, write/read, arbitration order, abort, reset mid-write.
// Latency : expects gnt in cycles 1-2, ack in cycle 2, bank update in cycle 3 after the request cycle.
// Backpressure: requesters hold req until ack and drop it in the cycle after.

module tb_flop_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                   clk_i;
    logic                   rst_i;
    logic [NREQ-1:0]        req_i;
    logic [NREQ-1:0]        we_i;
    logic [NREQ*AW-1:0]     addr_i;
    logic [NREQ*WIDTH-1:0]  wdata_i;
    logic [NREQ-1:0]        gnt_o;
    logic [NREQ-1:0]        ack_o;
    logic [WIDTH-1:0]       rdata_o;
    logic                   busy_o;
    logic [DEPTH*WIDTH-1:0] bank_q_o;

    int errors = 0;
    int checks = 0;

    flop_bank_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .gnt_o   (gnt_o),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .busy_o  (busy_o),
        .bank_q_o(bank_q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        req_i   = NREQ'($urandom);
        we_i    = NREQ'($urandom);
        addr_i  = (NREQ*AW)'($urandom);
        wdata_i = $urandom;
        tick();
        req_i   = NREQ'($urandom);
        we_i    = NREQ'($urandom);
        wdata_i = $urandom;
        tick();
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        rst_i   = 1'b0;
    endtask

    // One complete access by requester r; checks gnt in cycle 1 and ack/gnt (and rdata on reads) in cycle 2.
    task automatic access(input int r, input logic w, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_rd, input string tag);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << r;
        req_i[r]                = 1'b1;
        we_i[r]                 = w;
        addr_i[r*AW +: AW]      = a;
        wdata_i[r*WIDTH +: WIDTH] = d;
        tick();
        check({tag, "_gnt_c1"}, 32'(gnt_o), 32'(oh));
        tick();
        check({tag, "_ack_c2"}, 32'(ack_o), 32'(oh));
        if (!w) check({tag, "_rdata_c2"}, 32'(rdata_o), 32'(exp_rd));
        tick();
        req_i[r] = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] exp_g;
        rst_i   = 1'b1;
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;

        // 1. reset with random inputs
        do_reset();
        check("rst_gnt",   32'(gnt_o),   32'h0);
        check("rst_ack",   32'(ack_o),   32'h0);
        check("rst_busy",  32'(busy_o),  32'h0);
        check("rst_rdata", 32'(rdata_o), 32'h0);
        check("rst_bank",  bank_q_o,     32'h0);

        // 2. requester 0 writes A5 to entry 2
        access(0, 1'b1, 2'd2, 8'hA5, 8'h00, "wr0");
        check("wr0_bank_c3", 32'(bank_q_o[23:16]), 32'hA5);
        check("wr0_gnt_c3",  32'(gnt_o), 32'h0);
        check("wr0_busy_c3", 32'(busy_o), 32'h0);

        // 3. requester 1 reads entry 2; rdata holds afterwards
        access(1, 1'b0, 2'd2, 8'h00, 8'hA5, "rd1");
        tick();
        tick();
        check("rd1_rdata_hold", 32'(rdata_o), 32'hA5);

        // 4. req 0 and 1 held with pointer at 0
        do_reset();
        req_i = 4'b0011;
        we_i  = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            tick();
`ifdef FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = (n % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            check($sformatf("arb_gnt_%0d", n), 32'(gnt_o), 32'(exp_g));
            tick();
            tick();
        end
        req_i = '0;
        tick();
        check("arb_busy_end", 32'(busy_o), 32'h0);

        // 5. requester 2 aborts a write during GRANT
        req_i[2]       = 1'b1;
        we_i[2]        = 1'b1;
        addr_i[5:4]    = 2'd1;
        wdata_i[23:16] = 8'h77;
        tick();
        check("abort_gnt_c1",  32'(gnt_o),  32'h4);
        check("abort_busy_c1", 32'(busy_o), 32'h1);
        req_i[2] = 1'b0;
        tick();
        check("abort_busy_c2", 32'(busy_o), 32'h0);
        check("abort_gnt_c2",  32'(gnt_o),  32'h0);
        check("abort_ack_c2",  32'(ack_o),  32'h0);
        tick();
        check("abort_bank", bank_q_o, 32'h0);
        check("abort_ack_c3", 32'(ack_o), 32'h0);

        // give rdata a non-zero value so the reset below is observable
        access(0, 1'b1, 2'd0, 8'h5A, 8'h00, "wr5a");
        access(1, 1'b0, 2'd0, 8'h00, 8'h5A, "rd5a");

        // 6. reset arrives in the DONE cycle of a write of 3C
        req_i[3]       = 1'b1;
        we_i[3]        = 1'b1;
        addr_i[7:6]    = 2'd3;
        wdata_i[31:24] = 8'h3C;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i    = 1'b0;
        req_i    = '0;
        check("rstw_ack",   32'(ack_o),   32'h0);
        check("rstw_gnt",   32'(gnt_o),   32'h0);
        check("rstw_busy",  32'(busy_o),  32'h0);
        check("rstw_rdata", 32'(rdata_o), 32'h0);
        check("rstw_bank",  bank_q_o,     32'h0);
        tick();
        check("rstw_bank_after", 32'(bank_q_o[31:24]), 32'h0);
        check("rstw_ack_after",  32'(ack_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
